ps2_keyboard_rx: RTL and testbench

Parametrised PS/2 keyboard receiver that supersedes the fixed 26-key controller in the console top level. It synchronises and filters the PS/2 lines, deframes 11-bit frames, decodes E0/F0 prefixes into make/break events, and buffers those events in a show-ahead FIFO with a ready/valid handshake. It also maintains a per-key held-state vector for up to 32 game keys. It runs in the `clk_100` domain, between the keyboard pins and the game logic.

---
 rtl/ps2_keyboard_rx.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver. Synchronises and glitch-filters the
//               PS/2 pins, deframes 11-bit frames, folds E0/F0 prefixes into
//               make/break events, queues events in a show-ahead FIFO with a
//               ready/valid handshake and keeps a held-state bit per game key.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, reset_n             system clock / asynchronous active-low reset
//   ps2_clk, ps2_data        raw PS/2 pins (asynchronous)
//   key_status[NUM_KEYS]     1 = key held
//   evt_valid / evt_ready    FIFO head handshake
//   evt_code/evt_ext/evt_brk head event: scancode, E0-prefixed, break
//   fifo_count               entries currently queued
//   overflow/clear_overflow  sticky event-dropped flag and its clear
//   parity_err               one-cycle pulse on a bad-parity frame
// Build option:
//   PS2_RX_PARITY_CHECK_EN   when defined, bad-parity frames are discarded and
//                            flagged; otherwise the parity bit is ignored.
// ============================================================================
module ps2_keyboard_rx #(
    parameter int NUM_KEYS       = 26,
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic [NUM_KEYS-1:0]             key_status,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [7:0]                      evt_code,
    output logic                            evt_ext,
    output logic                            evt_brk,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    input  logic                            clear_overflow,
    output logic                            parity_err
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FLT_W-1:0] c_flt_last = FLT_W'(FILTER_LEN - 1);
    localparam logic [WD_W-1:0]  c_wd_last  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(FIFO_DEPTH);

    // {ext, code} per key index: A..Z, space, esc, up, down, left, right
    localparam logic [8:0] c_key_map [32] = '{
        9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033,
        9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D,
        9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022,
        9'h035, 9'h01A, 9'h029, 9'h076, 9'h175, 9'h172, 9'h16B, 9'h174
    };

    // ------------------------------------------------------------------
    // Input path: bit 0 = ps2_clk, bit 1 = ps2_data. Lines idle high, so
    // everything resets to 1 to avoid a spurious falling edge.
    // ------------------------------------------------------------------
    logic [1:0] w_pin;
    logic [1:0] w_filt;
    assign w_pin = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [1:0]       r_sync;
            logic             r_filt;
            logic [FLT_W-1:0] r_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_sync <= 2'b11;
                    r_filt <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_sync <= {r_sync[0], w_pin[gi]};
                    // The filtered line follows only after FILTER_LEN
                    // consecutive samples disagree with it.
                    if (r_sync[1] == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_flt_last) begin
                        r_filt <= r_sync[1];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + FLT_W'(1);
                    end
                end
            end
            assign w_filt[gi] = r_filt;
        end
    endgenerate

    logic r_clk_d;
    logic w_fall;
    logic w_data;
    assign w_data = w_filt[1];
    assign w_fall = r_clk_d & ~w_filt[0];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [WD_W-1:0] r_wd;
    logic            r_byte_vld, w_byte_vld_nxt;
    logic            w_timeout, w_par_good;

    // A strobe in the same cycle as expiry wins: it proves the line is alive.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wd == c_wd_last);

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_par;
    logic r_par_err;
    logic w_par_err_nxt;
    assign w_par_good = ^{r_shift, r_par};
    assign parity_err = r_par_err;
`else
    assign w_par_good = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_vld_nxt = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
        w_par_err_nxt  = 1'b0;
`endif
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!w_data) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt    = ST_IDLE;
                    w_byte_vld_nxt = w_data && w_par_good;
`ifdef PS2_RX_PARITY_CHECK_EN
                    w_par_err_nxt  = !w_par_good;
`endif
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_clk_d    <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_wd       <= '0;
            r_byte_vld <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            r_par      <= 1'b0;
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_clk_d    <= w_filt[0];
            r_byte_vld <= w_byte_vld_nxt;
`ifdef PS2_RX_PARITY_CHECK_EN
            r_par_err  <= w_par_err_nxt;
            if (w_fall && r_state == ST_PARITY) r_par <= w_data;
`endif
            if (w_fall && r_state == ST_IDLE) r_bit_cnt <= '0;
            if (w_fall && r_state == ST_DATA) begin
                r_shift   <= {w_data, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (r_state == ST_IDLE || w_fall) r_wd <= '0;
            else if (r_wd != c_wd_last)       r_wd <= r_wd + WD_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder and key map. r_shift holds the byte while
    // r_byte_vld is high because the FSM is back in IDLE.
    // ------------------------------------------------------------------
    logic                r_ext, r_brk;
    logic                w_push;
    logic [9:0]          w_evt;
    logic [NUM_KEYS-1:0] r_key_status;

    assign w_push = r_byte_vld && (r_shift != 8'hE0) && (r_shift != 8'hF0)
                                && (r_shift != 8'hE1);
    assign w_evt  = {r_ext, r_brk, r_shift};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_key_status <= '0;
        end else begin
            if (r_byte_vld) begin
                if (r_shift == 8'hE0)      r_ext <= 1'b1;
                else if (r_shift == 8'hF0) r_brk <= 1'b1;
                else if (r_shift != 8'hE1) begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
            if (w_push) begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if ({r_ext, r_shift} == c_key_map[k]) r_key_status[k] <= !r_brk;
                end
            end
        end
    end
    assign key_status = r_key_status;

    // ------------------------------------------------------------------
    // Show-ahead event FIFO
    // ------------------------------------------------------------------
    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_pop, w_full, w_wr;

    assign w_pop  = evt_valid & evt_ready;
    assign w_full = (r_count == c_depth);
    // A pop in the same cycle frees the slot the full FIFO needs.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int m = 0; m < FIFO_DEPTH; m++) r_mem[m] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_evt;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_wr && w_pop) r_count <= r_count - CNT_W'(1);
            if (w_push && !w_wr)     r_ovf <= 1'b1;
            else if (clear_overflow) r_ovf <= 1'b0;
        end
    end

    assign evt_valid                   = (r_count != '0);
    assign {evt_ext, evt_brk, evt_code} = r_mem[r_rd_ptr];
    assign fifo_count                  = r_count;
    assign overflow                    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ps2_keyboard_rx
// Description : Self-checking bench for ps2_keyboard_rx. Frames are driven on
//               the pins; an event-level model (byte stream -> events, key
//               table lookup, bounded queue) predicts the FIFO contents,
//               key_status and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_rx;
    localparam int NUM_KEYS       = 32;
    localparam int FIFO_DEPTH     = 8;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);

    logic                clk = 1'b0;
    logic                reset_n;
    logic                ps2_clk;
    logic                ps2_data;
    logic [NUM_KEYS-1:0] key_status;
    logic                evt_valid;
    logic                evt_ready = 1'b0;
    logic [7:0]          evt_code;
    logic                evt_ext;
    logic                evt_brk;
    logic [CNT_W-1:0]    fifo_count;
    logic                overflow;
    logic                clear_overflow;
    logic                parity_err;

    ps2_keyboard_rx #(
        .NUM_KEYS      (NUM_KEYS),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key_status    (key_status),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_ext       (evt_ext),
        .evt_brk       (evt_brk),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow),
        .parity_err    (parity_err)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [7:0]          kcode [32] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
        8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
        8'h35, 8'h1A, 8'h29, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74
    };
    bit                  kext [32] = '{
        0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,0,0,0,1,1,1,1
    };
    logic [9:0]          exp_q [$];
    logic [NUM_KEYS-1:0] exp_keys = '0;
    bit                  exp_ovf  = 1'b0;
    bit                  m_ext    = 1'b0;
    bit                  m_brk    = 1'b0;
    bit                  settled  = 1'b0;
    bit                  rand_ready  = 1'b0;
    bit                  ready_force = 1'b0;
    int                  exp_par     = 0;
    int                  n_par_pulse = 0;
    int                  n_checks    = 0;
    int                  n_fail      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-level model: prefixes set flags, other bytes become events.
    task automatic model_byte(input logic [7:0] b, input bit pop_same);
        if (b == 8'hE0)      m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE1) begin
            if (exp_q.size() >= FIFO_DEPTH && !pop_same) exp_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, b});
            for (int k = 0; k < NUM_KEYS; k++)
                if (kcode[k] == b && kext[k] == m_ext) exp_keys[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    always @(negedge clk) if (parity_err) n_par_pulse++;

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        ps2_data = b;
        repeat (12) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (25) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input bit pop_same);
        logic par;
        bit   ok;
        par = (~^b) ^ bad;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ok = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
        if (bad) begin
            ok = 1'b0;
            exp_par++;
        end
`endif
        settled = 1'b0;
        if (ok) model_byte(b, pop_same);
        @(posedge clk); #1;
        ps2_data = 1'b1;
        repeat (12) @(posedge clk);
        #1 ps2_clk = 1'b0;
        if (pop_same) begin
            // Stop strobe lands 2+FILTER_LEN cycles after the pin edge; the
            // push is committed two edges later. Hold ready for that edge only.
            repeat (11) @(posedge clk);
            ready_force = 1'b1;
            @(posedge clk);
            ready_force = 1'b0;
            repeat (13) @(posedge clk);
        end else begin
            repeat (25) @(posedge clk);
        end
        #1 ps2_clk = 1'b1;
        repeat (13) @(posedge clk);
        settled = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        ready_force = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (fifo_count == '0) done = 1'b1;
        end
        ready_force = 1'b0;
        check("drain_done", 64'(done), 64'(1));
        repeat (3) @(posedge clk);
    endtask

    task automatic pop_one();
        @(posedge clk);
        ready_force = 1'b1;
        @(posedge clk);
        ready_force = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic head_is(input string name, input logic [9:0] e);
        @(negedge clk);
        check({name, "_valid"}, 64'(evt_valid), 64'(1));
        check({name, "_head"}, 64'({evt_ext, evt_brk, evt_code}), 64'(e));
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("valid_vs_count", 64'(evt_valid), 64'(fifo_count != '0));
            if (settled) begin
                check("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
                check("key_status", 64'(key_status), 64'(exp_keys));
                check("overflow", 64'(overflow), 64'(exp_ovf));
            end
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got %0h expected no event",
                             {evt_ext, evt_brk, evt_code});
                end else begin
                    check("event_pop", 64'({evt_ext, evt_brk, evt_code}), 64'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        int par_before;
        reset_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        clear_overflow = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_key_status", 64'(key_status), 64'(0));
        check("rst_evt_valid", 64'(evt_valid), 64'(0));
        check("rst_evt_code", 64'(evt_code), 64'(0));
        check("rst_evt_ext", 64'(evt_ext), 64'(0));
        check("rst_evt_brk", 64'(evt_brk), 64'(0));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_parity_err", 64'(parity_err), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        settled = 1'b1;
        repeat (5) @(posedge clk);

        // Make then break of A
        send_frame(8'h1C, 0, 0);
        head_is("make_A", 10'h01C);
        check("make_A_key", 64'(key_status[0]), 64'(1));
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        @(negedge clk);
        check("break_A_key", 64'(key_status[0]), 64'(0));
        check("break_A_count", 64'(fifo_count), 64'(2));
        head_is("break_A_hold", 10'h01C);
        pop_one();
        head_is("break_A", 10'h11C);
        drain();

        // Extended keys
        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        head_is("make_up", 10'h275);
        check("make_up_key", 64'(key_status[28]), 64'(1));
        drain();
        send_frame(8'h75, 0, 0);
        head_is("plain_75", 10'h075);
        check("plain_75_key", 64'(key_status[28]), 64'(1));
        drain();
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        head_is("break_up", 10'h375);
        check("break_up_key", 64'(key_status[28]), 64'(0));
        drain();

        // Overflow, clear, and push/pop while full
        for (int i = 0; i <= FIFO_DEPTH; i++) send_frame(kcode[i], 0, 0);
        @(negedge clk);
        check("ovf_count", 64'(fifo_count), 64'(FIFO_DEPTH));
        check("ovf_flag", 64'(overflow), 64'(1));
        head_is("ovf_head", 10'h01C);
        @(posedge clk); #1;
        clear_overflow = 1'b1;
        @(posedge clk); #1;
        clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 64'(overflow), 64'(0));
        send_frame(8'h29, 0, 1);
        @(negedge clk);
        check("full_pushpop_count", 64'(fifo_count), 64'(FIFO_DEPTH));
        check("full_pushpop_ovf", 64'(overflow), 64'(0));
        head_is("full_pushpop_head", 10'h032);
        drain();

        // Bad parity
        par_before = n_par_pulse;
        send_frame(8'h1C, 1, 0);
        @(negedge clk);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("parity_pulses", 64'(n_par_pulse - par_before), 64'(1));
        check("parity_no_event", 64'(fifo_count), 64'(0));
`else
        check("parity_pulses", 64'(n_par_pulse - par_before), 64'(0));
        head_is("parity_ignored", 10'h01C);
`endif
        drain();

        // Watchdog: truncated frame, then a good frame must decode cleanly
        send_frame(8'hF0, 0, 0);
        send_frame(8'h29, 0, 0);
        drain();
        @(negedge clk);
        check("space_released", 64'(key_status[26]), 64'(0));
        send_bit(1'b0);
        repeat (5) send_bit(1'($urandom_range(0, 1)));
        repeat (TIMEOUT_CYCLES + 50) @(posedge clk);
        send_frame(8'h29, 0, 0);
        @(negedge clk);
        check("wd_count", 64'(fifo_count), 64'(1));
        check("wd_space_key", 64'(key_status[26]), 64'(1));
        head_is("wd_head", 10'h029);
        drain();

        // 3-cycle glitch on ps2_clk with data low must not start a frame
        @(posedge clk); #1;
        ps2_data = 1'b0;
        repeat (20) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1 ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(8'h1C, 0, 0);
        @(negedge clk);
        check("glitch_count", 64'(fifo_count), 64'(1));
        head_is("glitch_head", 10'h01C);
        drain();

        // Randomised byte stream with random consumer backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int         r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else if (r == 5) b = 8'($urandom_range(0, 255));
            else             b = kcode[$urandom_range(0, 31)];
            send_frame(b, ($urandom_range(0, 15) == 0), 0);
        end
        rand_ready = 1'b0;
        repeat (3) @(posedge clk);
        drain();
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));
        check("rand_parity_pulses", 64'(n_par_pulse), 64'(exp_par));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
